// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble/flush (pipelined) or a rotating
// one-hot stage enable (multi-cycle), with a halt/drain/resume sequencer.
module pipe_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter bit MULTI_CYCLE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [NUM_STAGES:0]   stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  flush_taken,
  output logic                  halted,
  output logic [NUM_STAGES-1:0] valid
);

  localparam int N = NUM_STAGES;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t         state_r, state_nxt;
  logic [N-1:0]   valid_r, valid_nxt;
  logic [N:0]     token_r, token_nxt;
  logic [N:0]     ssfx;
  logic [N:0]     fsfx;
  logic           blocked;
  logic           flush_acc;
  logic [N-1:0]   shifted;

  // Suffix-ORs: fsfx[i] = some flush at index >= i; a stall at or above the oldest
  // flushing stage blocks the flush. An accepted flush cancels every remaining stall.
  always_comb begin
    ssfx    = '0;
    fsfx    = '0;
    blocked = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      fsfx[i] = fsfx[i+1] | flush_req[i];
      blocked = blocked | (stall_req[i] & ~fsfx[i+1]);
    end
    flush_acc = fsfx[0] & ~blocked & (state_r != HALTED);
    for (int i = N - 1; i >= 0; i--) begin
      ssfx[i] = ssfx[i+1] | (stall_req[i] & ~flush_acc);
    end
  end

  // Hazard outputs, combinational from state and requests
  always_comb begin
    stall       = '0;
    bubble      = '0;
    flush       = '0;
    flush_taken = flush_acc;
    halted      = 1'b0;
    if (state_r == HALTED) begin
      stall  = '1;
      halted = 1'b1;
    end else if (MULTI_CYCLE) begin
      stall = ~token_r;
    end else begin
      stall = {ssfx[N-1:0], ssfx[0]};
      for (int i = 1; i < N; i++) begin
        bubble[i] = ssfx[i-1] & ~ssfx[i];
      end
      if (flush_acc) begin
        flush = fsfx[N:1];
      end else begin
        flush = '0;
      end
      if (state_r == DRAIN) begin
        stall[0]  = 1'b1;
        bubble[0] = ~stall[1];
      end else begin
        bubble[0] = 1'b0;
      end
    end
  end

  // Occupancy and token next-state
  always_comb begin
    shifted   = {valid_r[N-2:0], (state_r == RUN)};
    valid_nxt = '0;
    token_nxt = token_r;
    if (MULTI_CYCLE) begin
      if (flush_acc) begin
        token_nxt = {{N{1'b0}}, 1'b1};
      end else if ((state_r == HALTED) || (|stall_req)) begin
        token_nxt = token_r;
      end else begin
        token_nxt = {token_r[N-1:0], token_r[N]};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (flush[i] || bubble[i]) begin
          valid_nxt[i] = 1'b0;
        end else if (stall[i+1]) begin
          valid_nxt[i] = valid_r[i];
        end else begin
          valid_nxt[i] = shifted[i];
        end
      end
    end
  end

  // Halt sequencer next-state; a drain always completes once started
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      RUN: begin
        if (halt_req) state_nxt = DRAIN;
        else          state_nxt = RUN;
      end
      DRAIN: begin
        if (MULTI_CYCLE) begin
          if (token_r[N] && !(|stall_req) && !flush_acc) state_nxt = HALTED;
          else                                            state_nxt = DRAIN;
        end else begin
          if (valid_nxt == '0) state_nxt = HALTED;
          else                 state_nxt = DRAIN;
        end
      end
      HALTED: begin
        if (resume && !halt_req) state_nxt = RUN;
        else                     state_nxt = HALTED;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      valid_r <= '0;
      token_r <= {{N{1'b0}}, 1'b1};
    end else begin
      state_r <= state_nxt;
      valid_r <= valid_nxt;
      token_r <= token_nxt;
    end
  end

  assign valid = valid_r;

endmodule
